// File: rtl/audio_ctrl_mc_if.sv
// Write-only AXI-lite style bus (AW/W/B) used to program the audio controller.
interface audio_ctrl_mc_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic              BREADY;
  logic              BVALID;
  logic [1:0]        BRESP;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/audio_ctrl_mc.sv
// Multi-channel tone generator: per-channel phase accumulators produce square or
// triangle waves that are volume-scaled, mixed and emitted as a single PWM bit.
module audio_ctrl_mc #(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 7,
  parameter int ACC_W      = 16,
  parameter int SAMPLE_DIV = 64
) (
  input  logic            ACLK,
  input  logic            ARESET,
  audio_ctrl_mc_if.slave  bus,
  output logic            res_signal
);
  localparam int CH_W  = ADDR_W - 2;
  localparam int SH    = $clog2(NCH);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SUM_W = 8 + SH + 1;
  localparam logic [31:0] NCH_U = NCH;

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_A, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [ADDR_W-1:0]          addr_reg;
  logic [DATA_W-1:0]          data_reg;
  logic [1:0]                 bresp_reg;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [CH_W-1:0]            wr_ch;
  logic                       wr_legal;

  logic [NCH-1:0][DATA_W-1:0] phase_inc_reg;
  logic [NCH-1:0][DATA_W-1:0] volume_reg;
  logic [NCH-1:0][1:0]        mode_reg;
  logic [NCH-1:0][ACC_W-1:0]  acc_reg;
  logic [NCH-1:0][7:0]        scaled;
  logic [SUM_W-1:0]           sum;

  logic [CNT_W-1:0]           sample_cnt_reg;
  logic                       tick, tick_d_reg;
  logic [7:0]                 mix_reg, duty_reg, pwm_cnt_reg, pwm_cnt_next;
  logic                       res_reg;

  // Write FSM: the second of the two handshakes performs the register write.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = bus.AWADDR;
    wr_data    = bus.WDATA;
    case (state_reg)
      IDLE: begin
        if (bus.AWVALID && bus.WVALID) begin
          wr_en      = 1'b1;
          state_next = RESP;
        end else if (bus.AWVALID) begin
          state_next = WAIT_W;
        end else if (bus.WVALID) begin
          state_next = WAIT_A;
        end
      end
      WAIT_W: begin
        wr_addr = addr_reg;
        if (bus.WVALID) begin
          wr_en      = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_A: begin
        wr_data = data_reg;
        if (bus.AWVALID) begin
          wr_en      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.BREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ch    = wr_addr[ADDR_W-1:2];
  assign wr_legal = (wr_addr[1:0] != 2'b11) && (32'(wr_ch) < NCH_U);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      bresp_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.AWVALID && !bus.WVALID) addr_reg <= bus.AWADDR;
      if (state_reg == IDLE && bus.WVALID && !bus.AWVALID) data_reg <= bus.WDATA;
      if (wr_en) bresp_reg <= wr_legal ? 2'b00 : 2'b10;
    end
  end

  // Handshake outputs are forced low for as long as reset is held.
  assign bus.AWREADY = !ARESET && (state_reg == IDLE || state_reg == WAIT_A);
  assign bus.WREADY  = !ARESET && (state_reg == IDLE || state_reg == WAIT_W);
  assign bus.BVALID  = !ARESET && (state_reg == RESP);
  assign bus.BRESP   = bus.BVALID ? bresp_reg : 2'b00;

  assign tick = (sample_cnt_reg == CNT_W'(SAMPLE_DIV - 1));

  // Config registers and accumulators; an accumulator sees the register value
  // from before a write landing on the same tick.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      phase_inc_reg <= '0;
      volume_reg    <= '0;
      mode_reg      <= '0;
      acc_reg       <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && wr_legal && wr_ch == CH_W'(c)) begin
          case (wr_addr[1:0])
            2'd0:    phase_inc_reg[c] <= wr_data;
            2'd1:    volume_reg[c]    <= wr_data;
            2'd2:    mode_reg[c]      <= wr_data[1:0];
            default: ;
          endcase
        end
        if (tick) acc_reg[c] <= mode_reg[c][0] ? acc_reg[c] + ACC_W'(phase_inc_reg[c]) : '0;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_wave
    logic                   msb;
    logic [7:0]             tri_v;
    logic [7:0]             wave;
    logic [8+DATA_W-1:0]    prod;
    assign msb        = acc_reg[gi][ACC_W-1];
    assign tri_v      = msb ? ~acc_reg[gi][ACC_W-2 -: 8] : acc_reg[gi][ACC_W-2 -: 8];
    assign wave       = mode_reg[gi][1] ? tri_v : (msb ? 8'hFF : 8'h00);
    assign prod       = {{DATA_W{1'b0}}, wave} * {8'h00, volume_reg[gi]};
    assign scaled[gi] = mode_reg[gi][0] ? 8'(prod >> DATA_W) : 8'h00;
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < NCH; c++) sum = sum + SUM_W'(scaled[c]);
  end

  assign pwm_cnt_next = pwm_cnt_reg + 8'd1;

  // Mix is sampled one cycle after the tick so it reflects the new accumulators.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sample_cnt_reg <= '0;
      tick_d_reg     <= 1'b0;
      mix_reg        <= 8'h00;
      pwm_cnt_reg    <= 8'h00;
      duty_reg       <= 8'h00;
      res_reg        <= 1'b0;
    end else begin
      sample_cnt_reg <= tick ? '0 : sample_cnt_reg + 1'b1;
      tick_d_reg     <= tick;
      if (tick_d_reg) mix_reg <= 8'(sum >> SH);
      pwm_cnt_reg <= pwm_cnt_next;
      if (pwm_cnt_reg == 8'hFF) duty_reg <= mix_reg;
      res_reg <= (pwm_cnt_next < duty_reg);
    end
  end

  assign res_signal = res_reg && !ARESET;
endmodule

// File: tb/tb_audio_ctrl_mc.sv
// Directed bench for audio_ctrl_mc: bus handshakes, register map, tone path, resets.
module tb_audio_ctrl_mc;
  localparam int NCH = 2, ADDR_W = 4, DATA_W = 7, ACC_W = 16, SAMPLE_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  logic res_signal;
  always #5 clk = ~clk;

  audio_ctrl_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  audio_ctrl_mc #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W),
                  .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .ACLK(clk), .ARESET(rst), .bus(bus), .res_signal(res_signal));

  typedef struct {
    int                lead;  // >0: W leads AW by lead cycles, <0: AW leads
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] m_phase [NCH];
  logic [DATA_W-1:0] m_vol   [NCH];
  logic [1:0]        m_mode  [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = '0; m_vol[c] = '0; m_mode[c] = '0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int c = 0; c < NCH; c++) begin
      check({tag, " phase_inc"}, 32'(dut.phase_inc_reg[c]), 32'(m_phase[c]));
      check({tag, " volume"},    32'(dut.volume_reg[c]),    32'(m_vol[c]));
      check({tag, " mode"},      32'(dut.mode_reg[c]),      32'(m_mode[c]));
    end
  endtask

  task automatic wr(input int lead, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                    output logic [1:0] resp);
    bit done;
    @(negedge clk);
    if (lead >= 0) begin bus.WDATA = d; bus.WVALID = 1'b1; end
    if (lead <= 0) begin bus.AWADDR = a; bus.AWVALID = 1'b1; end
    if (lead != 0) begin
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      repeat ((lead < 0 ? -lead : lead) - 1) @(negedge clk);
      if (lead > 0) begin bus.AWADDR = a; bus.AWVALID = 1'b1; end
      else          begin bus.WDATA = d;  bus.WVALID = 1'b1;  end
    end
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      done = (!bus.AWVALID || bus.AWREADY) && (!bus.WVALID || bus.WREADY);
      @(negedge clk);
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("handshake_done", 32'(done), 1);
    check("bvalid_after_write", 32'(bus.BVALID), 1);
    resp = bus.BRESP;
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("bvalid_cleared", 32'(bus.BVALID), 0);
    $display("write lead=%0d addr=%0d data=%0d bresp=%0d", lead, a, d, resp);
  endtask

  task automatic wait_msb(input logic v, output int cyc);
    cyc = 0;
    while (dut.acc_reg[0][ACC_W-1] !== v && cyc < 6000) begin
      @(negedge clk); cyc++;
    end
    check("acc_msb_reached", 32'(dut.acc_reg[0][ACC_W-1]), 32'(v));
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (res_signal) cnt++;
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic [1:0]        resp;
    logic [ACC_W-1:0]  a;
    logic [7:0]        t;
    int                cyc, cnt, bcount, exp_mix;

    vecs[0] = '{0,  4'h4, 7'd33,  2'b00};
    vecs[1] = '{-2, 4'h5, 7'd90,  2'b00};
    vecs[2] = '{2,  4'h6, 7'h7E,  2'b00};
    vecs[3] = '{0,  4'h3, 7'd5,   2'b10};
    vecs[4] = '{0,  4'h8, 7'd9,   2'b10};
    vecs[5] = '{1,  4'hC, 7'd1,   2'b10};
    vecs[6] = '{-1, 4'h7, 7'd1,   2'b10};
    vecs[7] = '{0,  4'h6, 7'd0,   2'b00};
    vecs[8] = '{3,  4'h4, 7'd0,   2'b00};
    vecs[9] = '{0,  4'h5, 7'd0,   2'b00};

    clear_model();
    rst = 1'b1;
    bus.AWADDR = '0; bus.WDATA = 7'd99; bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;

    // Reset held three cycles with both valids high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {27'd0, bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, res_signal}, 0);
    end
    rst = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {30'd0, bus.AWREADY, bus.WREADY}, 3);
    check("bvalid_after_reset", 32'(bus.BVALID), 0);
    check_regs("post_reset");

    // Simultaneous write with BREADY withheld for 5 cycles.
    bus.AWADDR = 4'h0; bus.WDATA = 7'd60; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("sim_bvalid", 32'(bus.BVALID), 1);
    check("sim_bresp", 32'(bus.BRESP), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_bvalid", 32'(bus.BVALID), 1);
      check("hold_readys", {30'd0, bus.AWREADY, bus.WREADY}, 0);
    end
    check("sim_phase_inc0", 32'(dut.phase_inc_reg[0]), 60);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("sim_bvalid_clear", 32'(bus.BVALID), 0);
    m_phase[0] = 7'd60;
    $display("write lead=0 addr=0 data=60 bresp=0");

    // Split write: data leads address by 3 cycles.
    bus.WDATA = 7'd127; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    check("split_wready_low", 32'(bus.WREADY), 0);
    check("split_awready_high", 32'(bus.AWREADY), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("split_vol_before_aw", 32'(dut.volume_reg[0]), 0);
      check("split_no_bvalid", 32'(bus.BVALID), 0);
    end
    bus.AWADDR = 4'h1; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check("split_vol_after_aw", 32'(dut.volume_reg[0]), 127);
    check("split_bresp", {29'd0, bus.BVALID, bus.BRESP}, 4);
    bus.BREADY = 1'b1;
    bcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.BVALID && bus.BREADY) bcount++;
      @(negedge clk);
    end
    bus.BREADY = 1'b0;
    check("split_one_response", 32'(bcount), 1);
    m_vol[0] = 7'd127;
    $display("write lead=3 addr=1 data=127 bresp=0");

    // Register map table.
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].lead, vecs[i].addr, vecs[i].data, resp);
      check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
      if (vecs[i].resp == 2'b00) begin
        case (vecs[i].addr[1:0])
          2'd0: m_phase[vecs[i].addr[3:2]] = vecs[i].data;
          2'd1: m_vol[vecs[i].addr[3:2]]   = vecs[i].data;
          default: m_mode[vecs[i].addr[3:2]] = vecs[i].data[1:0];
        endcase
      end
      check_regs($sformatf("vec%0d", i));
    end

    // Square tone on ch0: 64 per tick, full volume -> mix 126, MSB every 512 ticks.
    wr(0, 4'h0, 7'd64, resp);
    wr(0, 4'h2, 7'd1, resp);
    wait_msb(1'b1, cyc);
    @(negedge clk);
    cyc = 0;
    repeat (300) @(negedge clk);
    check("square_mix", 32'(dut.mix_reg), 126);
    count_high(1024, cnt);
    check("square_high_count", 32'(cnt), 4 * 126);
    cyc = 300 + 1024 + 1;
    while (dut.acc_reg[0][ACC_W-1] !== 1'b0 && cyc < 6000) begin
      @(negedge clk); cyc++;
    end
    check("msb_half_period", 32'(cyc), 2048);
    repeat (300) @(negedge clk);
    count_high(1024, cnt);
    check("square_low_count", 32'(cnt), 0);

    // Triangle on ch0, frozen in the upper quarter by zeroing the increment.
    wr(0, 4'h0, 7'd127, resp);
    wr(0, 4'h2, 7'd3, resp);
    cyc = 0;
    while (dut.acc_reg[0][ACC_W-1 -: 2] !== 2'b11 && cyc < 6000) begin
      @(negedge clk); cyc++;
    end
    check("tri_upper_quarter", 32'(cyc < 6000), 1);
    wr(0, 4'h0, 7'd0, resp);
    repeat (20) @(negedge clk);
    a = dut.acc_reg[0];
    repeat (40) @(negedge clk);
    check("tri_acc_frozen", 32'(dut.acc_reg[0]), 32'(a));
    t = a[ACC_W-1] ? ~a[ACC_W-2 -: 8] : a[ACC_W-2 -: 8];
    exp_mix = ((int'(t) * 127) >> 7) >> 1;
    repeat (300) @(negedge clk);
    check("tri_mix", 32'(dut.mix_reg), 32'(exp_mix));
    count_high(256, cnt);
    check("tri_high_count", 32'(cnt), 32'(exp_mix));

    // Reset while a response is pending and the tone is running.
    bus.AWADDR = 4'h1; bus.WDATA = 7'd5; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("midrst_in_resp", 32'(bus.BVALID), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", 32'(bus.BVALID), 0);
    check("midrst_res", 32'(res_signal), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_model();
    check_regs("after_midrst");
    bcount = 0;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (res_signal) cnt++;
      if (bus.BVALID) bcount++;
    end
    check("midrst_output_quiet", 32'(cnt), 0);
    check("midrst_no_response", 32'(bcount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_ctrl_mc.md
Name: audio_ctrl_mc

Overview:
- Multi-channel successor to the single-tone audio controller.
- An AXI-lite-style write slave (AW/W/B channels) programs per-channel phase increment, volume and mode registers.
- Each channel runs a phase accumulator that produces a square or triangle wave. The channel outputs are volume-scaled, summed and driven out as one PWM bit, res_signal, to the audio output pin.

Parameters:
- NCH, 2: number of tone channels; must be a power of two, 1..8.
- ADDR_W, 4: AWADDR width; must be >= clog2(NCH)+2.
- DATA_W, 7: WDATA width and width of each config register.
- ACC_W, 16: phase accumulator width.
- SAMPLE_DIV, 64: ACLK cycles per sample tick; must be >= 2.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_W  write address; [1:0] = register select, [ADDR_W-1:2] = channel.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BREADY  in  1  response ready.
- BVALID  out  1  response valid.
- BRESP  out  2  response code: 00 = OKAY, 10 = SLVERR.
- res_signal  out  1  PWM audio output.

Behaviour:
- Reset:
  - ARESET high at a rising edge clears all registers, accumulators, the sample counter, the PWM counter and the mix register, and forces state IDLE.
  - While ARESET is high: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, res_signal=0.
  - Reset mid-transaction abandons that transaction; no B response is issued for it.
- Register map, per channel c:
  - reg 0 PHASE_INC.
  - reg 1 VOLUME.
  - reg 2 MODE: bit0 = enable, bit1 = wave (0 square, 1 triangle), other bits ignored.
  - reg 3, or c >= NCH: illegal.
- Write FSM states: IDLE, WAIT_W, WAIT_A, RESP.
  - IDLE: AWREADY=1, WREADY=1.
    - AWVALID and WVALID both high: perform the write, go to RESP.
    - AWVALID only: latch AWADDR, go to WAIT_W.
    - WVALID only: latch WDATA, go to WAIT_A.
  - WAIT_W: AWREADY=0, WREADY=1. On WVALID, perform the write and go to RESP.
  - WAIT_A: AWREADY=1, WREADY=0. On AWVALID, perform the write and go to RESP.
  - RESP: AWREADY=0, WREADY=0, BVALID=1.
    - BRESP=00 for a legal address; 10 for an illegal one, in which case no register changes.
    - On BREADY, go to IDLE. BVALID and BRESP stay stable until accepted.
- Write timing: the register updates at the edge where the second handshake completes; the new value is visible the next cycle. BVALID rises on that same edge, so the response comes 1 cycle after the completing handshake.
- Sample tick: a counter runs 0..SAMPLE_DIV-1; tick is asserted when it equals SAMPLE_DIV-1.
- Per channel, on each tick:
  - If enabled: acc <= acc + PHASE_INC, modulo 2^ACC_W (wraps silently).
  - If disabled: acc <= 0.
- Wave value, 8-bit unsigned, with m = acc[ACC_W-1]:
  - Square: all ones when m=1, else 0.
  - Triangle: ~acc[ACC_W-2:ACC_W-9] when m=1, else acc[ACC_W-2:ACC_W-9].
- Scaling: scaled = (wave * VOLUME) >> DATA_W, 8 bits. A disabled channel contributes 0.
- Mix register: on the cycle after a tick, mix <= (sum of scaled) >> clog2(NCH). The result is 8 bits and cannot overflow.
- PWM:
  - An 8-bit counter free-runs on ACLK.
  - When the counter equals 255, duty <= mix, so duty changes only at a period boundary.
  - res_signal is registered: res_signal <= (pwm_cnt_next < duty).
  - duty=0 gives constant 0; the maximum duty of 255 gives 255 of 256 cycles high.
- A register write that lands on the same cycle as a tick takes effect at the next tick.

Test Plan:
- Reset: hold ARESET 3 cycles with AWVALID=WVALID=1 -> all outputs 0 throughout. After release, the next cycle has AWREADY=WREADY=1 and no write has occurred.
- Simultaneous write: AWADDR=0, WDATA=60, both valid for one cycle -> BVALID=1, BRESP=00 the next cycle. With BREADY held 0 for 5 cycles, BVALID stays 1 and the ready signals stay 0. Ch0 PHASE_INC reads 60 in the internal probe.
- Split write: WVALID (data 127) asserted 3 cycles before AWVALID (addr 1) -> WREADY drops after its handshake. VOLUME0 is 127 only after the AW handshake, followed by exactly one B response.
- Illegal write: addr 3, then addr 8 with NCH=2 -> each gets BRESP=10, and all registers are unchanged.
- Tone path (NCH=2, SAMPLE_DIV=4): ch0 PHASE_INC=64, VOLUME=127, MODE=01 (square); ch1 off.
  - Scaled value = 253, so mix = 126.
  - res_signal is high 126 of every 256 cycles while acc0 MSB=1, and 0 while MSB=0.
  - The MSB toggles every 512 ticks.
- Reset mid-operation: assert ARESET while in RESP with tone running -> the next cycle has BVALID=0 and res_signal=0. After release, the regs are 0 and the output stays 0.
